// File: rtl/spi_word_arbiter_if.sv
// spi_word_arbiter_if
//   Bundles the requester side and the SPI transmitter side of the word
//   arbiter into one interface.
//   slave  : arbiter view (req, req_data, spi_done_send in; grant, busy,
//            spi_data_in, spi_load_data, timeout_err out)
//   master : requester/transmitter view, directions mirrored
interface spi_word_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req;
    logic [24*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic [23:0]           spi_data_in;
    logic                  spi_load_data;
    logic                  spi_done_send;
    logic                  timeout_err;

    modport slave (
        input  req, req_data, spi_done_send,
        output grant, busy, spi_data_in, spi_load_data, timeout_err
    );

    modport master (
        output req, req_data, spi_done_send,
        input  grant, busy, spi_data_in, spi_load_data, timeout_err
    );
endinterface

// File: rtl/spi_word_arbiter.sv
// spi_word_arbiter
//   Round-robin arbiter letting NUM_REQ requesters share one SPI word
//   transmitter. A granted word is latched, handed over with a load/done
//   handshake, and the requester is told via a one-cycle grant pulse. Each
//   handshake phase is guarded by a TIMEOUT_CYCLES watchdog.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : spi_word_arbiter_if.slave (requests, words, grants, SPI side)
module spi_word_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_word_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT_DONE, ACK} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_q;
    logic          done_s;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [23:0]   pick_data;
    logic [23:0]   data_q;
    logic [CW-1:0] cnt;
    logic          tmo;

    // spi_done_send lives in the transmitter clock domain. Flops reset to 1
    // so the transmitter looks ready straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], bus.spi_done_send};
    end
    assign done_s = sync_q[1];

    // Scan upward from last_grant+1 with wrap; first asserted req wins.
    always_comb begin
        int j;
        j        = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(last_grant) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!pick_vld && bus.req[IW'(j)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) pick_data = bus.req_data[24*i +: 24];
        end
    end

    assign tmo = ((state == LOAD) || (state == WAIT_DONE)) &&
                 (cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (|bus.req && done_s) state_nxt = ARB;
            ARB:       state_nxt = pick_vld ? LOAD : IDLE;
            LOAD: begin
                if (tmo)          state_nxt = IDLE;
                else if (!done_s) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tmo)         state_nxt = IDLE;
                else if (done_s) state_nxt = ACK;
            end
            ACK:       state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            data_q     <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            state <= state_nxt;

            // Word and index are captured only here, so req_data and req
            // changes later in the transfer have no effect.
            if (state == ARB && pick_vld) begin
                idx    <= pick_idx;
                data_q <= pick_data;
            end

            // A timed-out requester still loses its turn.
            if (state == ACK || tmo) last_grant <= idx;

            if ((state_nxt == LOAD && state != LOAD) ||
                (state_nxt == WAIT_DONE && state != WAIT_DONE))
                cnt <= '0;
            else if (state == LOAD || state == WAIT_DONE)
                cnt <= cnt + 1'b1;
        end
    end

    // Decoded straight from the state register so reset drops the load
    // request asynchronously.
    assign bus.busy          = (state != IDLE);
    assign bus.spi_load_data = (state == LOAD) && !tmo;
    assign bus.timeout_err   = tmo;
    assign bus.spi_data_in   = data_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant
        assign bus.grant[g] = (state == ACK) && (idx == IW'(g));
    end
endmodule

// File: tb/tb_spi_word_arbiter.sv
module tb_spi_word_arbiter;
    localparam int N = 4;
    localparam logic [23:0] W0 = 24'hA5C3F0;
    localparam logic [23:0] W1 = 24'h111111;
    localparam logic [23:0] W2 = 24'h3C3C3C;
    localparam logic [23:0] W3 = 24'h0F0F0F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_word_arbiter_if #(.NUM_REQ(N)) bus ();
    spi_word_arbiter_if #(.NUM_REQ(N)) bus_t ();

    spi_word_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    spi_word_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .bus(bus_t)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: accepts acc_dly cycles after seeing a load,
    // completes cmp_dly cycles after that.
    int          acc_dly = 3;
    int          cmp_dly = 40;
    int          loads   = 0;
    logic [23:0] cap     = '0;
    initial begin
        bus.spi_done_send = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && bus.spi_load_data) begin
                cap = bus.spi_data_in;
                loads++;
                repeat (acc_dly) @(negedge clk);
                bus.spi_done_send = 1'b0;
                repeat (cmp_dly) @(negedge clk);
                bus.spi_done_send = 1'b1;
            end
        end
    end

    // Invariants on both instances.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((bus.grant != 0 && bus.timeout_err) || (bus.spi_load_data && !bus.busy) ||
                !$onehot0(bus.grant) || (bus_t.grant != 0 && bus_t.timeout_err) ||
                (bus_t.spi_load_data && !bus_t.busy) || !$onehot0(bus_t.grant)) begin
                n_fail++;
                $display("FAIL invariant: grant=%b te=%b load=%b busy=%b | t: grant=%b te=%b load=%b",
                         bus.grant, bus.timeout_err, bus.spi_load_data, bus.busy,
                         bus_t.grant, bus_t.timeout_err, bus_t.spi_load_data);
            end
        end
    end

    task automatic wait_grant(output logic [N-1:0] g, output logic te);
        g  = '0;
        te = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (bus.grant != 0 || bus.timeout_err) begin
                g  = bus.grant;
                te = bus.timeout_err;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_grant: got no grant in 2000 cycles, required one");
    endtask

    task automatic wait_load(input logic lvl, input string nm);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.spi_load_data == lvl) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: spi_load_data never reached %0b", nm, lvl);
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           acc;
        int           cmp;
        logic [N-1:0] exp_g;
        logic [23:0]  exp_w;
    } vec_t;

    vec_t tbl [13];

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] g;
        logic         te;
        int           l0;
        int           n;
        logic         saw;

        tbl[0]  = '{4'b1111, 1, 6, 4'b0001, W0};
        tbl[1]  = '{4'b1111, 1, 6, 4'b0010, W1};
        tbl[2]  = '{4'b1111, 1, 6, 4'b0100, W2};
        tbl[3]  = '{4'b1111, 1, 6, 4'b1000, W3};
        tbl[4]  = '{4'b1111, 2, 4, 4'b0001, W0};
        tbl[5]  = '{4'b1111, 2, 4, 4'b0010, W1};
        tbl[6]  = '{4'b1111, 2, 4, 4'b0100, W2};
        tbl[7]  = '{4'b1111, 2, 4, 4'b1000, W3};
        tbl[8]  = '{4'b0001, 3, 40, 4'b0001, W0};
        tbl[9]  = '{4'b0110, 3, 10, 4'b0010, W1};
        tbl[10] = '{4'b0110, 3, 10, 4'b0100, W2};
        tbl[11] = '{4'b1001, 3, 10, 4'b1000, W3};
        tbl[12] = '{4'b1001, 3, 10, 4'b0001, W0};

        bus.req             = '0;
        bus.req_data        = {W3, W2, W1, W0};
        bus_t.req           = '0;
        bus_t.req_data      = {24'hDEAD03, 24'hDEAD02, 24'hDEAD01, 24'hDEAD00};
        bus_t.spi_done_send = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset grant", 32'(bus.grant), 0);
        chk("reset busy", 32'(bus.busy), 0);
        chk("reset load", 32'(bus.spi_load_data), 0);
        chk("reset data", 32'(bus.spi_data_in), 0);
        chk("reset timeout", 32'(bus.timeout_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Round-robin plus single-request vectors
        for (int i = 0; i < 13; i++) begin
            acc_dly = tbl[i].acc;
            cmp_dly = tbl[i].cmp;
            l0      = loads;
            bus.req = tbl[i].req;
            wait_grant(g, te);
            chk($sformatf("vec%0d grant", i), 32'(g), 32'(tbl[i].exp_g));
            chk($sformatf("vec%0d timeout", i), 32'(te), 0);
            chk($sformatf("vec%0d word", i), 32'(cap), 32'(tbl[i].exp_w));
            chk($sformatf("vec%0d data_at_grant", i), 32'(bus.spi_data_in), 32'(tbl[i].exp_w));
            chk($sformatf("vec%0d load_count", i), 32'(loads - l0), 1);
        end
        bus.req = '0;
        repeat (3) @(negedge clk);

        // req_data of requester 1 changes during WAIT_DONE
        acc_dly = 3;
        cmp_dly = 20;
        l0      = loads;
        bus.req = 4'b0010;
        wait_load(1'b1, "datachg load high");
        wait_load(1'b0, "datachg load low");
        bus.req_data[47:24] = 24'h222222;
        wait_grant(g, te);
        bus.req = '0;
        chk("datachg grant", 32'(g), 32'(4'b0010));
        chk("datachg data_at_grant", 32'(bus.spi_data_in), 32'h111111);
        chk("datachg word", 32'(cap), 32'h111111);
        chk("datachg load_count", 32'(loads - l0), 1);
        repeat (3) @(negedge clk);

        // Request withdrawn before ARB
        l0 = loads;
        bus.req = 4'b0100;
        @(negedge clk);
        bus.req = '0;
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.spi_load_data || bus.grant != 0) saw = 1'b1;
        end
        chk("withdraw activity", 32'(saw), 0);
        chk("withdraw busy", 32'(bus.busy), 0);
        chk("withdraw loads", 32'(loads - l0), 0);
        // last_grant untouched (still 1) -> requester 2 next
        bus.req = 4'b1111;
        wait_grant(g, te);
        bus.req = '0;
        chk("withdraw next grant", 32'(g), 32'(4'b0100));
        repeat (3) @(negedge clk);

        // Reset in the middle of LOAD
        acc_dly = 30;
        cmp_dly = 10;
        bus.req = 4'b0001;
        wait_load(1'b1, "rstload load high");
        rst_n = 1'b0;
        #1;
        chk("rstload load", 32'(bus.spi_load_data), 0);
        chk("rstload busy", 32'(bus.busy), 0);
        chk("rstload grant", 32'(bus.grant), 0);
        chk("rstload data", 32'(bus.spi_data_in), 0);
        bus.req = '0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b1000;
        wait_grant(g, te);
        chk("rstload grant after", 32'(g), 32'(4'b1000));
        chk("rstload word after", 32'(bus.spi_data_in), 32'(W3));
        acc_dly = 3;
        bus.req = 4'b0011;
        wait_grant(g, te);
        bus.req = '0;
        chk("post rst rr grant", 32'(g), 32'(4'b0001));
        repeat (3) @(negedge clk);

        // Idle reset restores requester 0 as highest priority (last was 0)
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0011;
        wait_grant(g, te);
        bus.req = '0;
        chk("prio after reset", 32'(g), 32'(4'b0001));
        repeat (3) @(negedge clk);

        // Stuck transmitter on the TIMEOUT_CYCLES=16 instance
        bus_t.req = 4'b0100;
        n = 0;
        while (!bus_t.spi_load_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo load seen", 32'(bus_t.spi_load_data), 1);
        n   = 0;
        saw = 1'b0;
        while (!bus_t.timeout_err && n < 100) begin
            @(negedge clk);
            n++;
            if (bus_t.grant != 0) saw = 1'b1;
        end
        bus_t.req = '0;
        chk("tmo latency", 32'(n), 16);
        chk("tmo load at err", 32'(bus_t.spi_load_data), 0);
        chk("tmo grant at err", 32'(bus_t.grant), 0);
        chk("tmo grant seen", 32'(saw), 0);
        @(negedge clk);
        chk("tmo pulse width", 32'(bus_t.timeout_err), 0);
        chk("tmo busy after", 32'(bus_t.busy), 0);
        // last_grant moved to 2, so requester 3 wins over 2
        bus_t.req = 4'b1100;
        n = 0;
        while (!bus_t.spi_load_data && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("tmo next word", 32'(bus_t.spi_data_in), 32'h00DEAD03);
        n = 0;
        while (!bus_t.timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus_t.req = '0;
        chk("tmo second err", 32'(bus_t.timeout_err), 1);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
